// File: rtl/four_input_nor_gate_b_reg.sv
// rtl/four_input_nor_gate_b_reg.sv - registered four-input NOR with g rising-edge counter
//
// Purpose:
//   Two-level network of 2-input NORs, registered. e and f are the partial
//   NORs of (a,b) and (c,d). g is the full four-input NOR. g_rise_cnt is a
//   saturating count of 0->1 transitions of g.
//
// Optional build macro: NOR4_SYNC_EN
//   When defined, a, b, c and d each pass through a 2-flop synchronizer
//   before the NOR network, so input-to-output latency becomes 3 cycles.
//   cnt_clr is never synchronized.
//
// Ports:
//   clk        in   rising-edge system clock
//   rst_n      in   asynchronous active-low reset
//   a, b, c, d in   NOR inputs
//   cnt_clr    in   synchronous clear of g_rise_cnt (wins over a rise)
//   e          out  registered ~(a|b)
//   f          out  registered ~(c|d)
//   g          out  registered ~(a|b|c|d)
//   g_rise_cnt out  saturating count of g rising edges, CNT_W bits

module four_input_nor_gate_b_reg #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             cnt_clr,
  output logic             e,
  output logic             f,
  output logic             g,
  output logic [CNT_W-1:0] g_rise_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic a_s;
  logic b_s;
  logic c_s;
  logic d_s;

`ifdef NOR4_SYNC_EN
  // Two flops per input; the network only ever sees the second stage.
  logic [3:0] sync_1;
  logic [3:0] sync_2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= {a, b, c, d};
      sync_2 <= sync_1;
    end
  end

  assign {a_s, b_s, c_s, d_s} = sync_2;
`else
  assign a_s = a;
  assign b_s = b;
  assign c_s = c;
  assign d_s = d;
`endif

  logic e_n;
  logic f_n;
  logic g_n;
  logic rise;

  assign e_n  = ~(a_s | b_s);
  assign f_n  = ~(c_s | d_s);
  // Second NOR level: NOR of the inverted partial NORs equals e_n & f_n.
  assign g_n  = ~(~e_n | ~f_n);
  // Compare the upcoming g against the registered one, so the first edge
  // after reset with all inputs low counts as a rise.
  assign rise = g_n & ~g;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e <= 1'b0;
      f <= 1'b0;
      g <= 1'b0;
    end else begin
      e <= e_n;
      f <= f_n;
      g <= g_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_rise_cnt <= '0;
    end else if (cnt_clr) begin
      g_rise_cnt <= '0;
    end else if (rise && (g_rise_cnt != CNT_MAX)) begin
      g_rise_cnt <= g_rise_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_four_input_nor_gate_b_reg.sv
// tb/tb_four_input_nor_gate_b_reg.sv - self-checking bench for four_input_nor_gate_b_reg

module tb_four_input_nor_gate_b_reg;

`ifdef NOR4_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       a, b, c, d;
  logic       cnt_clr;
  logic       e, f, g;
  logic [7:0] cnt8;
  logic       e2, f2, g2;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  four_input_nor_gate_b_reg #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .cnt_clr(cnt_clr),
    .e(e), .f(f), .g(g), .g_rise_cnt(cnt8)
  );

  four_input_nor_gate_b_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .cnt_clr(cnt_clr),
    .e(e2), .f(f2), .g(g2), .g_rise_cnt(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: inputs delayed by LAT-1 edges through a queue, outputs
  // computed from the NOR definitions, counters as clamped integers.
  logic [3:0] hist[$];
  int m_e, m_f, m_g, m_cnt8, m_cnt2;

  always @(posedge clk or negedge rst_n) begin : model
    logic [3:0] v;
    int ng;
    if (!rst_n) begin
      hist.delete();
      for (int i = 0; i < LAT - 1; i++) hist.push_back(4'd0);
      m_e <= 0; m_f <= 0; m_g <= 0; m_cnt8 <= 0; m_cnt2 <= 0;
    end else begin
      hist.push_back({a, b, c, d});
      v = hist.pop_front();
      ng = (v == 4'd0) ? 1 : 0;
      m_e <= (v[3:2] == 2'd0) ? 1 : 0;
      m_f <= (v[1:0] == 2'd0) ? 1 : 0;
      m_g <= ng;
      if (cnt_clr) begin
        m_cnt8 <= 0;
        m_cnt2 <= 0;
      end else if (ng == 1 && m_g == 0) begin
        m_cnt8 <= (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt2 <= (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
    end
  end

  bit model_on = 1'b0;

  always @(negedge clk) begin
    if (model_on) begin
      check("model_e", int'(e), m_e);
      check("model_f", int'(f), m_f);
      check("model_g", int'(g), m_g);
      check("model_cnt8", int'(cnt8), m_cnt8);
      check("model_cnt2", int'(cnt2), m_cnt2);
      check("g_eq_e_and_f", int'(g), int'(e & f));
    end
  end

  typedef struct {
    logic [3:0] in;
    logic       e;
    logic       f;
    logic       g;
  } vec_t;

  vec_t vecs[16];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] v);
    {a, b, c, d} = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    cnt_clr = 1'b0;
    drive(4'b0000);

    for (int i = 0; i < 16; i++) begin
      vecs[i].in = 4'(i);
      vecs[i].e  = (i / 4 == 0);
      vecs[i].f  = (i % 4 == 0);
      vecs[i].g  = (i == 0);
    end

    tick(2);
    check("rst_e", int'(e), 0);
    check("rst_g", int'(g), 0);
    check("rst_cnt", int'(cnt8), 0);
    rst_n = 1'b1;
    model_on = 1'b1;
    tick(3);

    // Reset asserted mid-cycle takes effect without a clock edge.
    drive(4'b0000);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_e", int'(e), 0);
    check("async_rst_f", int'(f), 0);
    check("async_rst_g", int'(g), 0);
    check("async_rst_cnt", int'(cnt8), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(LAT);
    check("post_rst_e", int'(e), 1);
    check("post_rst_f", int'(f), 1);
    check("post_rst_g", int'(g), 1);
    check("post_rst_cnt", int'(cnt8), 1);

    // Truth table.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].in);
      tick(LAT);
      check($sformatf("tt_e_%0d", i), int'(e), int'(vecs[i].e));
      check($sformatf("tt_f_%0d", i), int'(f), int'(vecs[i].f));
      check($sformatf("tt_g_%0d", i), int'(g), int'(vecs[i].g));
    end

    // Toggle d for 20 cycles from reset: 10 rises.
    drive(4'b0000);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      d = (i % 2 == 1);
      tick(1);
    end
    tick(LAT - 1);
    check("toggle_cnt", int'(cnt8), 10);

    // Saturation of the 2-bit counter.
    drive(4'b0001);
    do_reset();
    tick(LAT);
    for (int k = 0; k < 5; k++) begin
      d = 1'b0;
      tick(LAT);
      check($sformatf("sat_cnt2_%0d", k), int'(cnt2), (k + 1 < 3) ? k + 1 : 3);
      d = 1'b1;
      tick(LAT);
    end
    check("sat_cnt8", int'(cnt8), 5);

    // Clear coincides with a rise: clear wins.
    d = 1'b0;
    tick(LAT - 1);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    check("clr_prio_cnt", int'(cnt8), 0);
    check("clr_prio_g", int'(g), 1);
    d = 1'b1;
    tick(LAT);
    d = 1'b0;
    tick(LAT);
    check("clr_next_rise", int'(cnt8), 1);

    // Latency from a 1->0 to the g rise.
    drive(4'b1000);
    tick(LAT + 1);
    check("lat_g_low", int'(g), 0);
    a = 1'b0;
    n = 0;
    while (g !== 1'b1 && n < 10) begin
      @(posedge clk);
      n++;
      #1;
    end
    check("lat_edges", n, LAT);
    @(negedge clk);

    // Randomized stimulus checked by the model every cycle.
    for (int i = 0; i < 400; i++) begin
      drive(4'($urandom_range(0, 15)) & ((($urandom & 1) == 0) ? 4'h0 : 4'hF));
      cnt_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 149) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick(1);
    end
    cnt_clr = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
